// File: rtl/clk_phase_sequencer_pkg.sv
// Shared types and the phase-to-strobe decode for the machine-cycle clock sequencer.
// One decode function keeps every strobe derived from the same phase value.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic adr_p;
    logic adr_n;
    logic data_p;
    logic data_n;
    logic inc_p;
    logic inc_n;
    logic latch;
    logic main_p;
    logic main_n;
  } strobe_t;

  localparam strobe_t STROBES_IDLE = '{
    adr_p: 1'b0, adr_n: 1'b1, data_p: 1'b0, data_n: 1'b1,
    inc_p: 1'b0, inc_n: 1'b1, latch: 1'b0, main_p: 1'b0, main_n: 1'b1
  };

  function automatic strobe_t phase_strobes(input int idx, input int phases, input int latch_ph);
    strobe_t s;
    s.adr_p  = (idx >= 1);
    s.adr_n  = !s.adr_p;
    s.data_p = (idx >= phases / 2);
    s.data_n = !s.data_p;
    s.inc_p  = (idx == phases - 1);
    s.inc_n  = !s.inc_p;
    s.latch  = (idx == latch_ph);
    s.main_p = (idx == 0);
    s.main_n = !s.main_p;
    return s;
  endfunction

endpackage

// File: rtl/clk_phase_sequencer_if.sv
// Bundle between the sequencer and its consumers: oscillator/run inputs, phase strobes and status.
// STATE is a debug copy of the sequencer FSM register.
interface clk_phase_sequencer_if #(
  parameter int PHASES = 4,
  parameter int CNT_W  = 16
);
  import clk_seq_pkg::*;

  localparam int PH_W = $clog2(PHASES);

  // Run/stop handshake: CLK_ENA is a level request sampled at each machine-cycle wrap in RUN;
  // STOPPED high is the acknowledgement that the sequencer is parked, and it drops on the edge
  // that restarts phase 0 after CLK_ENA returns high.
  logic              OSC_ENA;
  logic              CLK_ENA;
  logic [PH_W-1:0]   PHASE_IDX;
  logic [PHASES-1:0] PHASE_OH;
  logic              ADR_CLK_P;
  logic              ADR_CLK_N;
  logic              DATA_CLK_P;
  logic              DATA_CLK_N;
  logic              INC_CLK_P;
  logic              INC_CLK_N;
  logic              LATCH_CLK;
  logic              MAIN_CLK_P;
  logic              MAIN_CLK_N;
  logic              OSC_STABLE;
  logic              SYNC_RESET;
  logic              STOPPED;
  logic [CNT_W-1:0]  M_CYCLE_CNT;
  seq_state_t        STATE;

  modport master (
    input  OSC_ENA, CLK_ENA,
    output PHASE_IDX, PHASE_OH, ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N,
           INC_CLK_P, INC_CLK_N, LATCH_CLK, MAIN_CLK_P, MAIN_CLK_N,
           OSC_STABLE, SYNC_RESET, STOPPED, M_CYCLE_CNT, STATE
  );

  modport slave (
    output OSC_ENA, CLK_ENA,
    input  PHASE_IDX, PHASE_OH, ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N,
           INC_CLK_P, INC_CLK_N, LATCH_CLK, MAIN_CLK_P, MAIN_CLK_N,
           OSC_STABLE, SYNC_RESET, STOPPED, M_CYCLE_CNT, STATE
  );

endinterface

// File: rtl/clk_phase_sequencer_osc_stable_timer.sv
// Saturating count of consecutive enabled cycles with a synchronous clear.
// hit_next is the next value of expired so the FSM can leave WAIT on the same edge.
module osc_stable_timer
  import clk_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit_next,
  output logic expired
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    expired_d = (cnt_d == SAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign hit_next = expired_d;
  assign expired  = expired_q;

endmodule

// File: rtl/clk_phase_sequencer.sv
// Machine-cycle clock sequencer: WAIT/HOLD/RUN/STOP FSM, phase counter, registered strobes
// and a completed-cycle counter. All outputs are decoded from next-state values and registered.
module clk_phase_sequencer
  import clk_seq_pkg::*;
#(
  parameter int PHASES        = 4,
  parameter int LATCH_PH      = 2,
  parameter int STABLE_CYCLES = 12,
  parameter int CNT_W         = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  clk_phase_sequencer_if.master bus
);

  localparam int PH_W = $clog2(PHASES);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(PHASES - 1);

  seq_state_t        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
  logic [PHASES-1:0] oh_q, oh_d;
  strobe_t           stb_q, stb_d;
  logic              sync_reset_q, sync_reset_d;
  logic              stopped_q, stopped_d;
  logic              running;
  logic              wrap;
  logic              timer_hit;
  logic              timer_expired;

  osc_stable_timer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_timer (
    .clk      (CLK),
    .rst      (RESET),
    .en       (state_q == WAIT),
    .clr      (!bus.OSC_ENA),
    .hit_next (timer_hit),
    .expired  (timer_expired)
  );

  assign wrap = (phase_q == LAST_PH);

  always_comb begin
    state_d = state_q;
    phase_d = '0;
    mcnt_d  = mcnt_q;
    case (state_q)
      WAIT: if (timer_hit) state_d = HOLD;
      HOLD: begin
        if (wrap) state_d = RUN;
        else      phase_d = phase_q + 1'b1;
      end
      RUN: begin
        if (wrap) begin
          mcnt_d = mcnt_q + 1'b1;
          if (!bus.CLK_ENA) state_d = STOP;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      STOP: if (bus.CLK_ENA) state_d = RUN;
      default: state_d = WAIT;
    endcase

    // Losing the oscillator abandons the cycle in progress; the interrupted wrap is not counted.
    if (!bus.OSC_ENA && (state_q != WAIT)) begin
      state_d = WAIT;
      phase_d = '0;
      mcnt_d  = mcnt_q;
    end

    running = (state_d == HOLD) || (state_d == RUN);
    stb_d   = running ? phase_strobes(int'(phase_d), PHASES, LATCH_PH) : STROBES_IDLE;
    oh_d    = '0;
    if (running) oh_d[phase_d] = 1'b1;
    sync_reset_d = (state_d == WAIT) || (state_d == HOLD);
    stopped_d    = (state_d == STOP);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= WAIT;
      phase_q      <= '0;
      mcnt_q       <= '0;
      oh_q         <= '0;
      stb_q        <= STROBES_IDLE;
      sync_reset_q <= 1'b1;
      stopped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      mcnt_q       <= mcnt_d;
      oh_q         <= oh_d;
      stb_q        <= stb_d;
      sync_reset_q <= sync_reset_d;
      stopped_q    <= stopped_d;
    end
  end

  assign bus.PHASE_IDX   = phase_q;
  assign bus.PHASE_OH    = oh_q;
  assign bus.ADR_CLK_P   = stb_q.adr_p;
  assign bus.ADR_CLK_N   = stb_q.adr_n;
  assign bus.DATA_CLK_P  = stb_q.data_p;
  assign bus.DATA_CLK_N  = stb_q.data_n;
  assign bus.INC_CLK_P   = stb_q.inc_p;
  assign bus.INC_CLK_N   = stb_q.inc_n;
  assign bus.LATCH_CLK   = stb_q.latch;
  assign bus.MAIN_CLK_P  = stb_q.main_p;
  assign bus.MAIN_CLK_N  = stb_q.main_n;
  assign bus.OSC_STABLE  = timer_expired;
  assign bus.SYNC_RESET  = sync_reset_q;
  assign bus.STOPPED     = stopped_q;
  assign bus.M_CYCLE_CNT = mcnt_q;
  assign bus.STATE       = state_q;

endmodule
